// File: rtl/cnt_mod16_axil_master.sv
// Single-outstanding AXI4-Lite master feeding the CNT_MOD16 slave: one command in,
// one AXI transaction, one response out, with a watchdog flag and a completion counter.
module cnt_mod16_axil_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    m00_axi_aclk,
    input  logic                    m00_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,
    output logic                    timeout,
    output logic [15:0]             txn_count,
    output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]              m00_axi_awprot,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,
    output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                    m00_axi_wvalid,
    input  logic                    m00_axi_wready,
    input  logic [1:0]              m00_axi_bresp,
    input  logic                    m00_axi_bvalid,
    output logic                    m00_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]              m00_axi_arprot,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]              m00_axi_rresp,
    input  logic                    m00_axi_rvalid,
    output logic                    m00_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WD_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WD_WIDTH-1:0] WD_ONE   = WD_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    state_t                  r_state,     w_state_nxt;
    logic                    r_cmd_ready, w_cmd_ready_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr,      w_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,     w_wdata_nxt;
    logic [STRB_WIDTH-1:0]   r_wstrb,     w_wstrb_nxt;
    logic                    r_awvalid,   w_awvalid_nxt;
    logic                    r_wvalid,    w_wvalid_nxt;
    logic                    r_bready,    w_bready_nxt;
    logic                    r_arvalid,   w_arvalid_nxt;
    logic                    r_rready,    w_rready_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]              r_rsp_resp,  w_rsp_resp_nxt;
    logic                    r_rsp_write, w_rsp_write_nxt;
    logic                    r_timeout,   w_timeout_nxt;
    logic [15:0]             r_txn_count, w_txn_count_nxt;
    logic [WD_WIDTH-1:0]     r_wd_cnt,    w_wd_cnt_nxt;
    logic                    w_busy;

    // Next-state and next-register computation for the transaction FSM and watchdog
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_rsp_write_nxt = r_rsp_write;
        w_txn_count_nxt = r_txn_count;

        // Watchdog saturates at its limit so the flag cannot re-fire on wrap
        w_busy = (r_state == ST_WADDR) || (r_state == ST_WRESP) ||
                 (r_state == ST_RADDR) || (r_state == ST_RDATA);
        if (w_busy && (r_wd_cnt != WD_LIMIT)) begin
            w_wd_cnt_nxt = r_wd_cnt + WD_ONE;
        end else begin
            w_wd_cnt_nxt = r_wd_cnt;
        end
        w_timeout_nxt = r_timeout | (w_wd_cnt_nxt == WD_LIMIT);

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = cmd_wdata;
                    w_wstrb_nxt     = cmd_wstrb;
                    w_rsp_write_nxt = cmd_write;
                    w_timeout_nxt   = 1'b0;
                    w_wd_cnt_nxt    = '0;
                    if (cmd_write) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = ST_WADDR;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_RADDR;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (r_awvalid && m00_axi_awready) begin
                    w_awvalid_nxt = 1'b0;
                end else begin
                    w_awvalid_nxt = r_awvalid;
                end
                if (r_wvalid && m00_axi_wready) begin
                    w_wvalid_nxt = 1'b0;
                end else begin
                    w_wvalid_nxt = r_wvalid;
                end
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WRESP;
                end else begin
                    w_state_nxt  = ST_WADDR;
                end
            end
            ST_WRESP: begin
                if (m00_axi_bvalid && r_bready) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_resp_nxt  = m00_axi_bresp;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RSP;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (r_arvalid && m00_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RDATA;
                end else begin
                    w_state_nxt = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (m00_axi_rvalid && r_rready) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_resp_nxt  = m00_axi_rresp;
                    w_rsp_rdata_nxt = m00_axi_rdata;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RSP;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_txn_count_nxt = r_txn_count + 16'd1;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RSP;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b1;
                w_awvalid_nxt   = 1'b0;
                w_wvalid_nxt    = 1'b0;
                w_bready_nxt    = 1'b0;
                w_arvalid_nxt   = 1'b0;
                w_rready_nxt    = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every AXI valid at once
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_write <= 1'b0;
            r_timeout   <= 1'b0;
            r_txn_count <= 16'd0;
            r_wd_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_timeout   <= w_timeout_nxt;
            r_txn_count <= w_txn_count_nxt;
            r_wd_cnt    <= w_wd_cnt_nxt;
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_resp        = r_rsp_resp;
    assign rsp_write       = r_rsp_write;
    assign timeout         = r_timeout;
    assign txn_count       = r_txn_count;
    assign m00_axi_awaddr  = r_addr;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = r_awvalid;
    assign m00_axi_wdata   = r_wdata;
    assign m00_axi_wstrb   = r_wstrb;
    assign m00_axi_wvalid  = r_wvalid;
    assign m00_axi_bready  = r_bready;
    assign m00_axi_araddr  = r_addr;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = r_arvalid;
    assign m00_axi_rready  = r_rready;

endmodule

// File: tb/tb_cnt_mod16_axil_master.sv
// Directed bench for cnt_mod16_axil_master: a configurable-wait AXI-Lite slave model
// plus hand-computed latencies, payloads and watchdog/reset behaviour.
module tb_cnt_mod16_axil_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] txn_count;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration and captures
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    logic [3:0]  cap_awaddr, cap_araddr, cap_wstrb;
    logic [31:0] cap_wdata;

    // monitor counters
    int   aw_hi = 0, w_hi = 0, ar_hi = 0, rsp_cnt = 0;
    logic aw_moved = 1'b0, b_early = 1'b0;

    cnt_mod16_axil_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout(timeout), .txn_count(txn_count),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AXI-Lite slave model: ready/valid asserted after the configured wait counts
    initial begin : slave
        logic hs_aw, hs_w, hs_b, hs_ar, hs_r, got_aw, got_w, got_ar;
        int   aw_c, w_c, b_c, ar_c, r_c;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        forever begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            if (hs_aw) cap_awaddr = awaddr;
            if (hs_w) begin cap_wdata = wdata; cap_wstrb = wstrb; end
            if (hs_ar) cap_araddr = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
                got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
            end else begin
                if (hs_aw) begin awready = 1'b0; got_aw = 1'b1; aw_c = 0; end
                else if (awvalid && !awready) begin
                    if (aw_c >= aw_wait) awready = 1'b1; else aw_c++;
                end
                if (hs_w) begin wready = 1'b0; got_w = 1'b1; w_c = 0; end
                else if (wvalid && !wready) begin
                    if (w_c >= w_wait) wready = 1'b1; else w_c++;
                end
                if (hs_b) begin bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; b_c = 0; end
                else if (got_aw && got_w && !bvalid) begin
                    if (b_c >= b_wait) begin bvalid = 1'b1; bresp = cfg_bresp; end else b_c++;
                end
                if (hs_ar) begin arready = 1'b0; got_ar = 1'b1; ar_c = 0; end
                else if (arvalid && !arready) begin
                    if (ar_c >= ar_wait) arready = 1'b1; else ar_c++;
                end
                if (hs_r) begin rvalid = 1'b0; got_ar = 1'b0; r_c = 0; end
                else if (got_ar && !rvalid) begin
                    if (r_c >= r_wait) begin
                        rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp;
                    end else r_c++;
                end
            end
        end
    end

    // Protocol monitor sampled mid-cycle
    initial begin : monitor
        logic       prev_aw, prev_rsp;
        logic [3:0] prev_addr;
        prev_aw = 1'b0; prev_rsp = 1'b0; prev_addr = 4'h0;
        forever begin
            @(negedge clk);
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (arvalid) ar_hi++;
            if (awvalid && prev_aw && (awaddr != prev_addr)) aw_moved = 1'b1;
            if (bready && (awvalid || wvalid)) b_early = 1'b1;
            if (rsp_valid && !prev_rsp) rsp_cnt++;
            prev_aw = awvalid; prev_addr = awaddr; prev_rsp = rsp_valid;
        end
    end

    task automatic clr_mon();
        aw_hi = 0; w_hi = 0; ar_hi = 0; rsp_cnt = 0; aw_moved = 1'b0; b_early = 1'b0;
    endtask

    // Present one command in the accept cycle; returns in cycle 2
    task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 2;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rsp_valid}, 64'd0);
        chk("rst_txn", {48'd0, txn_count}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        rst_n = 1'b1;
        tick();

        // zero-wait write
        clr_mon();
        issue(1'b1, 4'h0, 32'h0000_0001, 4'hF);
        wait_rsp(lat);
        chk("w0_lat", lat, 64'd4);
        chk("w0_resp", {62'd0, rsp_resp}, 64'd0);
        chk("w0_write", {63'd0, rsp_write}, 64'd1);
        chk("w0_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("w0_aw_hi", aw_hi, 64'd1);
        chk("w0_w_hi", w_hi, 64'd1);
        chk("w0_slave_data", {28'd0, cap_awaddr, cap_wdata}, {28'd0, 4'h0, 32'h0000_0001});
        chk("w0_cmd_busy", {63'd0, cmd_ready}, 64'd0);
        take_rsp();
        chk("w0_rsp_drop", {63'd0, rsp_valid}, 64'd0);
        chk("w0_txn", {48'd0, txn_count}, 64'd1);
        chk("w0_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // awready delayed 3 cycles, wready immediate
        clr_mon(); aw_wait = 3; cfg_bresp = 2'b00;
        issue(1'b1, 4'h8, 32'h1234_5678, 4'h3);
        wait_rsp(lat);
        chk("w1_lat", lat, 64'd7);
        chk("w1_w_hi", w_hi, 64'd1);
        chk("w1_aw_hi", aw_hi, 64'd4);
        chk("w1_aw_stable", {63'd0, aw_moved}, 64'd0);
        chk("w1_b_early", {63'd0, b_early}, 64'd0);
        chk("w1_slave", {24'd0, cap_awaddr, cap_wstrb, cap_wdata}, {24'd0, 4'h8, 4'h3, 32'h1234_5678});
        take_rsp();
        chk("w1_rsp_cnt", rsp_cnt, 64'd1);
        chk("w1_txn", {48'd0, txn_count}, 64'd2);
        aw_wait = 0;

        // read with two R wait cycles
        clr_mon(); r_wait = 2; cfg_rdata = 32'h0000_000A; cfg_rresp = 2'b00;
        issue(1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("r0_lat", lat, 64'd6);
        chk("r0_rdata", {32'd0, rsp_rdata}, 64'h0000_000A);
        chk("r0_resp", {62'd0, rsp_resp}, 64'd0);
        chk("r0_write", {63'd0, rsp_write}, 64'd0);
        chk("r0_araddr", {60'd0, cap_araddr}, 64'h4);
        chk("r0_ar_hi", ar_hi, 64'd1);
        take_rsp();
        chk("r0_txn", {48'd0, txn_count}, 64'd3);

        // SLVERR read, response back-pressured for 5 cycles
        r_wait = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
        issue(1'b0, 4'hC, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("r1_lat", lat, 64'd4);
        for (int i = 0; i < 5; i++) begin
            chk("r1_hold", {60'd0, rsp_valid, cmd_ready, rsp_resp}, {60'd0, 1'b1, 1'b0, 2'b10});
            chk("r1_hold_data", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
            tick();
        end
        take_rsp();
        chk("r1_txn", {48'd0, txn_count}, 64'd4);
        cfg_rresp = 2'b00;

        // watchdog: bvalid withheld 20 cycles, TIMEOUT_CYCLES=8
        b_wait = 20; cfg_bresp = 2'b11;
        issue(1'b1, 4'h2, 32'hA5A5_0000, 4'h1);
        lat = 2;
        while (!rsp_valid && lat < 100) begin
            if (lat == 6) chk("to_early", {63'd0, timeout}, 64'd0);
            if (lat == 12) chk("to_set", {62'd0, timeout, bready}, 64'd3);
            tick();
            lat++;
        end
        chk("to_lat", lat, 64'd24);
        chk("to_resp", {61'd0, rsp_valid, rsp_resp}, {61'd0, 1'b1, 2'b11});
        chk("to_in_rsp", {63'd0, timeout}, 64'd1);
        take_rsp();
        chk("to_sticky", {63'd0, timeout}, 64'd1);
        chk("to_txn", {48'd0, txn_count}, 64'd5);
        b_wait = 0; cfg_bresp = 2'b00;
        issue(1'b1, 4'h1, 32'h0000_0007, 4'hF);
        chk("to_clear", {63'd0, timeout}, 64'd0);
        wait_rsp(lat);
        chk("unaligned_addr", {60'd0, cap_awaddr}, 64'h1);
        take_rsp();
        chk("txn6", {48'd0, txn_count}, 64'd6);

        // reset while arvalid is high
        clr_mon(); ar_wait = 50;
        issue(1'b0, 4'h4, 32'h0, 4'h0);
        tick();
        chk("rst_mid_arvalid_pre", {63'd0, arvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_arvalid", {63'd0, arvalid}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ar_wait = 0;
        repeat (4) tick();
        chk("rst_mid_after", {46'd0, cmd_ready, rsp_valid, txn_count}, {46'd0, 1'b1, 1'b0, 16'd0});
        chk("rst_mid_no_rsp", rsp_cnt, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/cnt_mod16_axil_master.md
Name: cnt_mod16_axil_master

Overview:
- Single-outstanding AXI4-Lite master that sits directly upstream of the CNT_MOD16 AXI-Lite slave and drives its s00_axi_* port.
- Converts a simple valid/ready command stream (write or read, one register per command) into AXI4-Lite transactions.
- Returns each transaction's response on a valid/ready response stream.
- Provides a watchdog timeout flag and a wrapping transaction counter for debug within the DFX test design.

Parameters:
ADDR_WIDTH, 4, AXI-Lite byte address width (matches slave awaddr/araddr)
DATA_WIDTH, 32, AXI-Lite data width; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, cycles from address issue to B/R handshake before the timeout flag sets (>=2)

Ports:
m00_axi_aclk  in  1  clock, all logic on rising edge
m00_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  register byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  captured BRESP/RRESP
rsp_write  out  1  echo of cmd_write
timeout  out  1  sticky watchdog flag for current transaction
txn_count  out  16  completed transactions, wraps 0xFFFF->0
m00_axi_awaddr  out  ADDR_WIDTH
m00_axi_awprot  out  3  constant 3'b000
m00_axi_awvalid  out  1
m00_axi_awready  in  1
m00_axi_wdata  out  DATA_WIDTH
m00_axi_wstrb  out  DATA_WIDTH/8
m00_axi_wvalid  out  1
m00_axi_wready  in  1
m00_axi_bresp  in  2
m00_axi_bvalid  in  1
m00_axi_bready  out  1
m00_axi_araddr  out  ADDR_WIDTH
m00_axi_arprot  out  3  constant 3'b000
m00_axi_arvalid  out  1
m00_axi_arready  in  1
m00_axi_rdata  in  DATA_WIDTH
m00_axi_rresp  in  2
m00_axi_rvalid  in  1
m00_axi_rready  out  1

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All valid/ready outputs 0 except cmd_ready=1.
  - Address, data, strobe, rsp_* registers 0; timeout=0; txn_count=0.
  - Reset mid-transaction drops all AXI valids immediately; no response is produced.
- States: IDLE, WADDR (AW/W phase), WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready=1; on cmd_valid&cmd_ready, register addr/wdata/wstrb/write and clear timeout.
  - Next cycle: write -> WADDR with awvalid=wvalid=1; read -> RADDR with arvalid=1.
- Registered outputs: all AXI outputs come from registers; no combinational path from AXI inputs to AXI outputs.
- WADDR:
  - awvalid and wvalid are tracked independently. Each drops the cycle after its own handshake (valid&ready sampled high); neither drops before its handshake.
  - Both handshakes in the same cycle is legal.
  - When both are done -> WRESP with bready=1.
- WRESP:
  - On bvalid&bready, capture bresp into rsp_resp, set rsp_rdata=0, bready=0 -> RSP.
  - A bvalid arriving before both AW and W handshakes complete is ignored (bready=0).
- RADDR: arvalid held until arready; then arvalid=0, rready=1 -> RDATA.
- RDATA: on rvalid&rready, capture rdata/rresp, rready=0 -> RSP.
- RSP:
  - rsp_valid=1; payload stable until rsp_ready.
  - On handshake: rsp_valid=0, txn_count+1, -> IDLE.
  - The next command can be accepted the cycle after.
- Latency with a zero-wait slave:
  - Write: cmd accept -> rsp_valid = 4 cycles (accept, AW/W, B, RSP).
  - Read: 4 cycles (accept, AR, R, RSP).
- Watchdog:
  - A counter starts at address issue and counts while in WADDR/WRESP/RADDR/RDATA.
  - Reaching TIMEOUT_CYCLES sets timeout=1 (sticky until the next command accept).
  - The transaction is not abandoned; protocol is preserved and waiting continues.
- Non-OKAY responses (SLVERR/DECERR) are passed through unmodified; they are not treated as errors internally.
- Unaligned cmd_addr is passed through unchanged.

Test Plan:
- Write addr 0x0 data 0x00000001 strb 0xF, slave always ready, bresp=OKAY -> AW/W both valid 1 cycle; rsp_valid at cycle 4; rsp_resp=00, rsp_write=1, txn_count=1.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable; bready only after both handshakes; single response.
- Read addr 0x4, slave returns rdata=0x0000000A rresp=OKAY after 2 wait cycles -> rsp_rdata=0x0000000A, rsp_resp=00, rsp_write=0.
- Read returning rresp=SLVERR, with rsp_ready held low 5 cycles -> rsp_resp=10 stable; rsp_valid held; cmd_ready=0 throughout.
- TIMEOUT_CYCLES=8, slave withholds bvalid 20 cycles -> timeout=1 from cycle 8; completion still reported; next command clears timeout.
- Assert m00_axi_aresetn low while arvalid=1 -> arvalid=0 immediately; cmd_ready=1, txn_count=0 after release; no rsp_valid.
